// File: rtl/uart_rx_frame_receiver_if.sv
// Serial-line and received-word bundle between a UART line source and the
// frame receiver. The receiver takes the slave side; whoever drives the line
// and consumes the words takes the master side.
interface uart_rx_frame_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 IN_RX_SERIAL;
  logic [DATA_BITS-1:0] OUT_RX_DATA;
  logic                 OUT_RX_DATA_READY;
  logic                 OUT_RX_ERROR;
  logic                 OUT_RX_ACTIVE;

  modport master (
    output IN_RX_SERIAL,
    input  OUT_RX_DATA,
    input  OUT_RX_DATA_READY,
    input  OUT_RX_ERROR,
    input  OUT_RX_ACTIVE
  );

  modport slave (
    input  IN_RX_SERIAL,
    output OUT_RX_DATA,
    output OUT_RX_DATA_READY,
    output OUT_RX_ERROR,
    output OUT_RX_ACTIVE
  );
endinterface

// File: rtl/uart_rx_frame_receiver.sv
// UART receive engine: synchronises the serial line, samples start/data/
// parity/stop at bit centres and presents each word with a one-cycle ready
// strobe plus an error strobe for parity or framing faults. A line held low
// after a framing error is treated as a break and reported only once.
module uart_rx_frame_receiver #(
  parameter int UART_BAUD_RATE           = 9600,
  parameter int CLOCK_FREQUENCY          = 38400,
  parameter int PARITY                   = 2,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int NUMBER_STOP_BITS         = 1
) (
  input  logic IN_CLOCK,
  input  logic IN_RESET_N,
  uart_rx_frame_receiver_if.slave rx_if
);

  localparam int CLKS    = CLOCK_FREQUENCY / UART_BAUD_RATE;
  localparam int HALF    = CLKS / 2;
  localparam int CW      = $clog2(CLKS);
  localparam int IW      = $clog2(NUM_OF_DATA_BITS_IN_PACK + 1);
  localparam int N       = NUM_OF_DATA_BITS_IN_PACK;
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS - 1);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] DATA_LAST = IW'(N - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(NUMBER_STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_BREAK  = 3'd6
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [IW-1:0]  idx_r;
  logic [N-1:0]   shift_r;
  logic           perr_r;
  logic           ferr_r;
  logic           sync1_r;
  logic           sync2_r;
  logic           rx_s;
  logic [N-1:0]   data_r;
  logic           ready_r;
  logic           error_r;
  logic           active_r;

  // Parity bit the transmitter should have sent for a given data word.
  function automatic logic parity_expected(input logic [N-1:0] d);
    logic p;
    p = ^d;
    if (PAR_ODD) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

  assign rx_s = sync2_r;

  // Two-stage synchroniser for the asynchronous serial line, idle-high reset.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_if.IN_RX_SERIAL;
      sync2_r <= sync1_r;
    end
  end

  // Frame FSM: bit timing, shifting, error flags and registered outputs.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      shift_r  <= {N{1'b0}};
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      data_r   <= {N{1'b0}};
      ready_r  <= 1'b0;
      error_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          error_r <= 1'b0;
          cnt_r   <= CNT_ZERO;
          idx_r   <= IDX_ZERO;
          if (!rx_s) begin
            state_r  <= ST_START;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            active_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end
        end

        ST_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= CNT_ZERO;
            if (!rx_s) begin
              state_r <= ST_DATA;
            end else begin
              // Start bit vanished by mid-bit: a glitch, not a frame.
              state_r  <= ST_IDLE;
              active_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            shift_r <= {rx_s, shift_r[N-1:1]};
            if (idx_r == DATA_LAST) begin
              idx_r   <= IDX_ZERO;
              state_r <= PAR_EN ? ST_PARITY : ST_STOP;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= CNT_ZERO;
            perr_r  <= (rx_s != parity_expected(shift_r));
            state_r <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r  <= CNT_ZERO;
            ferr_r <= ferr_r | ~rx_s;
            if (idx_r == STOP_LAST) begin
              // Last stop sample: publish the word in the same edge so the
              // strobe lines up with the DONE cycle.
              idx_r   <= IDX_ZERO;
              state_r <= ST_DONE;
              data_r  <= shift_r;
              ready_r <= 1'b1;
              error_r <= perr_r | ferr_r | ~rx_s;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          ready_r <= 1'b0;
          error_r <= 1'b0;
          cnt_r   <= CNT_ZERO;
          idx_r   <= IDX_ZERO;
          if (ferr_r) begin
            state_r  <= ST_BREAK;
            active_r <= 1'b0;
          end else if (!rx_s) begin
            // Start edge already here: accept it without losing a cycle.
            state_r  <= ST_START;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            active_r <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end
        end

        ST_BREAK: begin
          ready_r  <= 1'b0;
          error_r  <= 1'b0;
          active_r <= 1'b0;
          if (rx_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BREAK;
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= CNT_ZERO;
          idx_r    <= IDX_ZERO;
          ready_r  <= 1'b0;
          error_r  <= 1'b0;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.OUT_RX_DATA       = data_r;
  assign rx_if.OUT_RX_DATA_READY = ready_r;
  assign rx_if.OUT_RX_ERROR      = error_r;
  assign rx_if.OUT_RX_ACTIVE     = active_r;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Directed bench for uart_rx_frame_receiver: a default-parameter receiver
// (even parity, 1 stop) and an odd-parity, 2-stop receiver for back-to-back
// frames. Four clocks per bit in both.
module tb_uart_rx_frame_receiver;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  uart_rx_frame_receiver_if #(.DATA_BITS(8)) ifa ();
  uart_rx_frame_receiver_if #(.DATA_BITS(8)) ifb ();

  uart_rx_frame_receiver u_dut_a (
    .IN_CLOCK   (clk),
    .IN_RESET_N (rst_n),
    .rx_if      (ifa)
  );

  uart_rx_frame_receiver #(
    .PARITY           (1),
    .NUMBER_STOP_BITS (2)
  ) u_dut_b (
    .IN_CLOCK   (clk),
    .IN_RESET_N (rst_n),
    .rx_if      (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorders, sampled on the falling edge.
  int         a_cnt = 0;
  int         a_cyc = 0;
  logic [7:0] a_data = 8'h00;
  logic       a_err = 1'b0;
  int         b_cnt = 0;
  int         b_cyc0 = 0;
  int         b_cyc1 = 0;
  logic [7:0] b_d0 = 8'h00;
  logic [7:0] b_d1 = 8'h00;
  logic       b_e0 = 1'b0;
  logic       b_e1 = 1'b0;

  always @(negedge clk) begin
    if (ifa.OUT_RX_DATA_READY) begin
      a_cnt  <= a_cnt + 1;
      a_cyc  <= cyc;
      a_data <= ifa.OUT_RX_DATA;
      a_err  <= ifa.OUT_RX_ERROR;
    end
  end

  always @(negedge clk) begin
    if (ifb.OUT_RX_DATA_READY) begin
      b_cnt <= b_cnt + 1;
      if (b_cnt == 0) begin
        b_cyc0 <= cyc;
        b_d0   <= ifb.OUT_RX_DATA;
        b_e0   <= ifb.OUT_RX_ERROR;
      end else if (b_cnt == 1) begin
        b_cyc1 <= cyc;
        b_d1   <= ifb.OUT_RX_DATA;
        b_e1   <= ifb.OUT_RX_ERROR;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive n bits LSB-first on line A, four clocks each; k = cycle of first edge.
  task automatic send_a(input logic [31:0] bits, input int n, output int k);
    @(posedge clk); #1;
    k = cyc;
    for (int i = 0; i < n; i++) begin
      ifa.IN_RX_SERIAL = bits[i];
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_b(input logic [31:0] bits, input int n, output int k);
    @(posedge clk); #1;
    k = cyc;
    for (int i = 0; i < n; i++) begin
      ifb.IN_RX_SERIAL = bits[i];
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  int k;
  int base;
  int act_cnt;
  int max_run;
  int run;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    ifa.IN_RX_SERIAL = 1'b1;
    ifb.IN_RX_SERIAL = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_data",   ifa.OUT_RX_DATA,       32'h0);
    check("rst_ready",  ifa.OUT_RX_DATA_READY, 32'h0);
    check("rst_error",  ifa.OUT_RX_ERROR,      32'h0);
    check("rst_active", ifa.OUT_RX_ACTIVE,     32'h0);

    // 0xCD, even parity bit 1, stop 1: strobe at fall+2+43
    base = a_cnt;
    send_a({21'h0, 1'b1, 1'b1, 8'hCD, 1'b0}, 11, k);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("cd_count", a_cnt - base, 32'd1);
    check("cd_cycle", a_cyc - k,    32'd45);
    check("cd_data",  a_data,       32'hCD);
    check("cd_err",   a_err,        32'h0);

    // 0xCD with wrong parity bit 0
    base = a_cnt;
    send_a({21'h0, 1'b1, 1'b0, 8'hCD, 1'b0}, 11, k);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("perr_count", a_cnt - base, 32'd1);
    check("perr_data",  a_data,       32'hCD);
    check("perr_err",   a_err,        32'h1);

    // 0x5A (even parity 0) with stop bit 0, then line held low 20 bit times
    base = a_cnt;
    send_a({21'h0, 1'b0, 1'b0, 8'h5A, 1'b0}, 11, k);
    repeat (4) @(posedge clk);
    act_cnt = 0;
    for (int i = 0; i < 76; i++) begin
      @(negedge clk);
      if (ifa.OUT_RX_ACTIVE) act_cnt++;
    end
    #1 ifa.IN_RX_SERIAL = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("brk_count",  a_cnt - base, 32'd1);
    check("brk_data",   a_data,       32'h5A);
    check("brk_err",    a_err,        32'h1);
    check("brk_active", act_cnt,      32'd0);

    // Clean 0x33 (even parity 0) after the break
    base = a_cnt;
    send_a({21'h0, 1'b1, 1'b0, 8'h33, 1'b0}, 11, k);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post_brk_count", a_cnt - base, 32'd1);
    check("post_brk_cycle", a_cyc - k,    32'd45);
    check("post_brk_data",  a_data,       32'h33);
    check("post_brk_err",   a_err,        32'h0);

    // One-clock glitch: active for HALF cycles, then idle, no strobe
    base = a_cnt;
    @(posedge clk); #1 ifa.IN_RX_SERIAL = 1'b0;
    @(posedge clk); #1 ifa.IN_RX_SERIAL = 1'b1;
    act_cnt = 0;
    max_run = 0;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifa.OUT_RX_ACTIVE) begin
        act_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    check("glitch_count",  a_cnt - base,      32'd0);
    check("glitch_active", act_cnt,           32'd2);
    check("glitch_run_ok", (max_run <= 3),    32'd1);
    check("glitch_idle",   ifa.OUT_RX_ACTIVE, 32'h0);

    // Reset during data bit 4 of a 0x96 frame, then a clean 0xA5
    base = a_cnt;
    send_a({27'h0, 4'h6, 1'b0}, 5, k);
    ifa.IN_RX_SERIAL = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    ifa.IN_RX_SERIAL = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_count",  a_cnt - base,      32'd0);
    check("abort_data",   ifa.OUT_RX_DATA,   32'h0);
    check("abort_active", ifa.OUT_RX_ACTIVE, 32'h0);
    send_a({21'h0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, k);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("a5_count", a_cnt - base, 32'd1);
    check("a5_cycle", a_cyc - k,    32'd45);
    check("a5_data",  a_data,       32'hA5);
    check("a5_err",   a_err,        32'h0);

    // Odd parity, 2 stop bits: 0x01 (par 0) and 0xFE (par 0) back to back
    send_b({8'h0, 2'b11, 1'b0, 8'hFE, 1'b0, 2'b11, 1'b0, 8'h01, 1'b0}, 24, k);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("b2b_count",  b_cnt,           32'd2);
    check("b2b_first",  b_cyc0 - k,      32'd49);
    check("b2b_gap",    b_cyc1 - b_cyc0, 32'd48);
    check("b2b_data0",  b_d0,            32'h01);
    check("b2b_data1",  b_d1,            32'hFE);
    check("b2b_err0",   b_e0,            32'h0);
    check("b2b_err1",   b_e1,            32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
